// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and the host read path.
// Define RXFIFO_FWFT_EN for first-word-fall-through reads.
module uart_rx_fifo #(
   parameter int DATA_BITS = 8,
   parameter int ADDR_W    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [DATA_BITS-1:0] wr_data,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 rd_valid,
   input  logic                 bist_mode,
   input  logic [ADDR_W:0]      afull_thresh,
   input  logic                 clr_ovf,
   output logic [ADDR_W:0]      level,
   output logic                 empty,
   output logic                 full,
   output logic                 almost_full,
   output logic                 overflow,
   output logic                 underflow
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int LVL_W = ADDR_W + 1;
   localparam logic [LVL_W-1:0]  DEPTH_L = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0]  LVL_ONE = LVL_W'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   logic [DATA_BITS-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;
   logic              afull_q, afull_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              rd_acc, wr_acc;

   always_comb begin
      rd_acc = rd_en & ~empty_q & ~bist_mode;
      wr_acc = wr_en & ~bist_mode & (~full_q | rd_acc);

      wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;

      level_d = level_q;
      if (wr_acc && !rd_acc) begin
         level_d = level_q + LVL_ONE;
      end else if (rd_acc && !wr_acc) begin
         level_d = level_q - LVL_ONE;
      end

      empty_d = (level_d == '0);
      full_d  = (level_d == DEPTH_L);

      // BIST freezes the threshold compare and the sticky flag too
      afull_d = afull_q;
      ovf_d   = ovf_q;
      if (!bist_mode) begin
         afull_d = (level_d >= afull_thresh);
         ovf_d   = (wr_en & full_q & ~rd_acc) | (ovf_q & ~clr_ovf);
      end
      udf_d = rd_en & empty_q & ~bist_mode;
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         afull_q  <= afull_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

`ifdef RXFIFO_FWFT_EN
   // Head word shows through; zero while empty so reset reads as 0
   assign rd_data  = empty_q ? '0 : mem_q[rd_ptr_q];
   assign rd_valid = ~empty_q;
`else
   logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
   logic                 rd_valid_q, rd_valid_d;

   always_comb begin
      rd_data_d  = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
      rd_valid_d = rd_acc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
`endif

   assign level       = level_q;
   assign empty       = empty_q;
   assign full        = full_q;
   assign almost_full = afull_q;
   assign overflow    = ovf_q;
   assign underflow   = udf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo against a queue-based model.
// Define RXFIFO_FWFT_EN here too when building the FWFT variant.
module tb_uart_rx_fifo;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en, rd_en, bist_mode, clr_ovf;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic [AW:0]   afull_thresh;
   logic [AW:0]   level;
   logic          empty, full, almost_full, overflow, underflow;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] q[$];
   logic [DW-1:0] m_rd_data;
   logic          m_valid, m_ovf, m_udf, m_afull;

   uart_rx_fifo #(.DATA_BITS(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_data(wr_data),
      .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
      .bist_mode(bist_mode), .afull_thresh(afull_thresh),
      .clr_ovf(clr_ovf), .level(level), .empty(empty),
      .full(full), .almost_full(almost_full),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string ph);
      logic [DW-1:0] ed;
      logic          ev;
`ifdef RXFIFO_FWFT_EN
      ed = (q.size() > 0) ? q[0] : '0;
      ev = (q.size() > 0);
`else
      ed = m_rd_data;
      ev = m_valid;
`endif
      chk({ph, ".level"}, 32'(level), 32'(q.size()));
      chk({ph, ".empty"}, 32'(empty), 32'(q.size() == 0));
      chk({ph, ".full"}, 32'(full), 32'(q.size() == DEPTH));
      chk({ph, ".afull"}, 32'(almost_full), 32'(m_afull));
      chk({ph, ".ovf"}, 32'(overflow), 32'(m_ovf));
      chk({ph, ".udf"}, 32'(underflow), 32'(m_udf));
      chk({ph, ".valid"}, 32'(rd_valid), 32'(ev));
      chk({ph, ".data"}, 32'(rd_data), 32'(ed));
   endtask

   task automatic model_reset();
      q.delete();
      m_rd_data = '0;
      m_valid = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_afull = 1'b0;
   endtask

   // One clock: drive inputs, step the model, then check after the edge
   task automatic cycle(input string ph, input logic w, input logic r,
                        input logic c, input logic b, input logic [DW-1:0] d);
      bit pop_ok, push_ok;
      wr_en = w; rd_en = r; clr_ovf = c; bist_mode = b; wr_data = d;
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      m_udf = 1'b0;
      if (!b) begin
         pop_ok  = r && q.size() > 0;
         push_ok = w && (q.size() < DEPTH || pop_ok);
         m_udf   = r && q.size() == 0;
         if (pop_ok) begin
            m_rd_data = q.pop_front();
            m_valid = 1'b1;
         end
         if (push_ok) q.push_back(d);
         if (w && !push_ok) m_ovf = 1'b1;
         else if (c) m_ovf = 1'b0;
         m_afull = (q.size() >= int'(afull_thresh));
      end
      check_all(ph);
      wr_en = 0; rd_en = 0; clr_ovf = 0; bist_mode = 0;
   endtask

   initial begin
      rst = 1'b1;
      wr_en = 0; rd_en = 0; bist_mode = 0; clr_ovf = 0;
      wr_data = '0;
      afull_thresh = 5'd12;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;

      for (int i = 0; i < 16; i++) cycle("fill", 1, 0, 0, 0, DW'(i));
      chk("fill.full_end", 32'(full), 32'd1);

      cycle("ovf_push", 1, 0, 0, 0, 8'hAA);
      chk("ovf_set", 32'(overflow), 32'd1);
      cycle("ovf_clr", 0, 0, 1, 0, 8'h00);
      cycle("ovf_setwins", 1, 0, 1, 0, 8'hAA);
      chk("ovf_setwins_val", 32'(overflow), 32'd1);
      cycle("ovf_clr2", 0, 0, 1, 0, 8'h00);

      for (int i = 0; i < 16; i++) cycle("drain", 0, 1, 0, 0, 8'h00);
      cycle("underflow", 0, 1, 0, 0, 8'h00);
      cycle("udf_gone", 0, 0, 0, 0, 8'h00);

      for (int i = 0; i < 16; i++) cycle("refill", 1, 0, 0, 0, DW'(i));
      cycle("full_rw", 1, 1, 0, 0, 8'h55);
      for (int i = 0; i < 40; i++)
         cycle("rand", 1'($urandom), 1'($urandom),
               ($urandom_range(7) == 0), 0, DW'($urandom));

      while (q.size() > 0) cycle("drain2", 0, 1, 0, 0, 8'h00);
      cycle("empty_rw", 1, 1, 0, 0, 8'h33);
      cycle("idle", 0, 0, 0, 0, 8'h00);
      for (int i = 0; i < 5; i++)
         cycle("bist", 1'($urandom), 1'($urandom), 1'($urandom), 1,
               DW'($urandom));

      while (q.size() < 7) cycle("to7", 1, 0, 0, 0, DW'($urandom));
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("midrst");
      rst = 1'b0;

      afull_thresh = 5'd0;
      cycle("thr0", 0, 0, 0, 0, 8'h00);
      afull_thresh = 5'd17;
      for (int i = 0; i < 17; i++) cycle("thr17", 1, 0, 0, 0, DW'(i));
      afull_thresh = 5'd16;
      cycle("thr16", 0, 0, 0, 0, 8'h00);
      for (int i = 0; i < 60; i++)
         cycle("rand2", 1'($urandom), 1'($urandom),
               ($urandom_range(5) == 0), ($urandom_range(9) == 0),
               DW'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
